alu_multicycle_flags: RTL and testbench

//  Sequential, parametrised successor to the combinational datapath ALU. It adds:
//   - a valid/ready operand handshake;
//   - a registered result;
//   - an architectural NZCV status register that feeds its own C back as carry-in;
//   - single-cycle shifts;
//   - an iterative shift-add multiply.

---
 rtl/alu_multicycle_flags_if.sv | 10 +
 rtl/alu_multicycle_flags.sv | 122 ++++++++++++
 tb/tb_alu_multicycle_flags.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_multicycle_flags_if.sv
// alu_multicycle_flags_if: operand handshake, result and status bundle for the multi-cycle ALU
interface alu_multicycle_flags_if #(parameter int W = 8);
  logic in_valid, in_ready, update_flags, out_valid, busy;
  logic [W-1:0] inp_src0, inp_src1, out_alu;
  logic [3:0] operation_select, flags_nzcv;
  modport master(output in_valid, inp_src0, inp_src1, operation_select, update_flags,
                 input in_ready, out_valid, out_alu, flags_nzcv, busy);
  modport slave(input in_valid, inp_src0, inp_src1, operation_select, update_flags,
                output in_ready, out_valid, out_alu, flags_nzcv, busy);
endinterface

// File: rtl/alu_multicycle_flags.sv
// alu_multicycle_flags: handshaked ALU with registered result, NZCV register and iterative multiply
module alu_multicycle_flags #(parameter int W = 8) (
  input logic clk,
  input logic reset,
  alu_multicycle_flags_if.slave bus
);
  localparam int SHW = $clog2(W) + 1;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_n;
  logic [W-1:0] a, b, res, m_op, s_op, ma, mb, acc, acc_n;
  logic [CW-1:0] cnt;
  logic [3:0] op;
  logic [SHW-1:0] n;
  logic [W:0] add_r, sub_r;
  logic [2*W-1:0] shl, shr, sar;
  logic cin, c_n, v_n, accept, ms;
  assign a = bus.inp_src0;
  assign b = bus.inp_src1;
  assign op = bus.operation_select;
  assign n = bus.inp_src1[SHW-1:0];
  assign cin = bus.flags_nzcv[1];
  assign bus.in_ready = state == IDLE;
  assign bus.busy = state == MUL;
  assign accept = bus.in_valid && bus.in_ready;
  assign acc_n = acc + (mb[0] ? ma : '0);
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = (accept && op == 4'd8) ? MUL : IDLE;
    else state_n = (cnt == LAST) ? IDLE : MUL;
  end
  // ops 3/7 swap minuend and subtrahend; ops 6/7 borrow an extra 1 when Cin is clear
  always_comb begin
    m_op = op[0] ? b : a;
    s_op = op[0] ? a : b;
    add_r = {1'b0, a} + {1'b0, b} + (W+1)'(op[0] & cin);
    sub_r = {1'b0, m_op} - {1'b0, s_op} - (W+1)'(op[2] & ~cin);
    shl = {{W{1'b0}}, a} << n;
    shr = {a, {W{1'b0}}} >> n;
    sar = $signed({a, {W{1'b0}}}) >>> n;
    res = a;
    c_n = 1'b0;
    v_n = 1'b0;
    case (op)
      4'd0: res = a & b;
      4'd1: res = a ^ b;
      4'd2, 4'd3, 4'd6, 4'd7: begin
        res = sub_r[W-1:0];
        c_n = sub_r[W];
        v_n = (m_op[W-1] != s_op[W-1]) && (sub_r[W-1] == s_op[W-1]);
      end
      4'd4, 4'd5: begin
        res = add_r[W-1:0];
        c_n = add_r[W];
        v_n = (a[W-1] == b[W-1]) && (add_r[W-1] != a[W-1]);
      end
      4'd9: begin
        res = shl[W-1:0];
        c_n = n == '0 ? cin : shl[W];
        v_n = bus.flags_nzcv[0];
      end
      4'd10: begin
        res = shr[2*W-1:W];
        c_n = n == '0 ? cin : shr[W-1];
        v_n = bus.flags_nzcv[0];
      end
      4'd11: begin
        res = sar[2*W-1:W];
        c_n = n == '0 ? cin : sar[W-1];
        v_n = bus.flags_nzcv[0];
      end
      4'd12: res = a | b;
      4'd13: res = b;
      4'd14: res = a & ~b;
      4'd15: res = ~b;
      default: begin
        c_n = cin;
        v_n = bus.flags_nzcv[0];
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus.out_alu <= '0;
      bus.out_valid <= 1'b0;
      bus.flags_nzcv <= '0;
      cnt <= '0;
      ma <= '0;
      mb <= '0;
      acc <= '0;
      ms <= 1'b0;
    end else begin
      state <= state_n;
      bus.out_valid <= 1'b0;
      if (state == IDLE && accept) begin
        if (op == 4'd8) begin
          ma <= a;
          mb <= b;
          acc <= '0;
          cnt <= '0;
          ms <= bus.update_flags;
        end else begin
          bus.out_alu <= res;
          bus.out_valid <= 1'b1;
          if (bus.update_flags) bus.flags_nzcv <= {res[W-1], res == '0, c_n, v_n};
        end
      end else if (state == MUL) begin
        acc <= acc_n;
        ma <= ma << 1;
        mb <= mb >> 1;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          bus.out_alu <= acc_n;
          bus.out_valid <= 1'b1;
          if (ms) bus.flags_nzcv[3:2] <= {acc_n[W-1], acc_n == '0};
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_multicycle_flags.sv
// tb_alu_multicycle_flags: directed vectors with hand-computed results for the W=8 ALU
module tb_alu_multicycle_flags;
  logic clk = 1'b0;
  logic reset;
  int n_checks = 0;
  int n_fail = 0;
  alu_multicycle_flags_if #(.W(8)) bus();
  alu_multicycle_flags #(.W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic s);
    bus.in_valid = 1'b1;
    bus.operation_select = op;
    bus.inp_src0 = a;
    bus.inp_src1 = b;
    bus.update_flags = s;
    step();
    bus.in_valid = 1'b0;
  endtask
  task automatic expect_op(input string tag, input logic [7:0] r, input logic [3:0] f);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_res"}, 32'(bus.out_alu), 32'(r));
    check({tag, "_nzcv"}, 32'(bus.flags_nzcv), 32'(f));
  endtask
  initial begin
    int cyc, busy_cnt, seen;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.operation_select = 4'd0;
    bus.inp_src0 = 8'h00;
    bus.inp_src1 = 8'h00;
    bus.update_flags = 1'b0;
    repeat (2) step();
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_res", 32'(bus.out_alu), 32'd0);
    check("rst_nzcv", 32'(bus.flags_nzcv), 32'd0);
    reset = 1'b0;
    step();
    send(4'd4, 8'h7F, 8'h01, 1'b1);
    expect_op("add_ovf", 8'h80, 4'b1001);
    step();
    check("add_pulse", 32'(bus.out_valid), 32'd0);
    check("add_hold", 32'(bus.out_alu), 32'h80);
    send(4'd4, 8'hFF, 8'h01, 1'b1);
    expect_op("add_carry", 8'h00, 4'b0110);
    send(4'd5, 8'h00, 8'h00, 1'b0);
    expect_op("adc_fwd", 8'h01, 4'b0110);
    send(4'd2, 8'h05, 8'h05, 1'b0);
    expect_op("sub_nos", 8'h00, 4'b0110);
    send(4'd8, 8'd13, 8'd11, 1'b1);
    bus.in_valid = 1'b1;
    bus.operation_select = 4'd4;
    bus.inp_src0 = 8'h01;
    bus.inp_src1 = 8'h01;
    bus.update_flags = 1'b1;
    check("mul_ready", 32'(bus.in_ready), 32'd0);
    cyc = 1;
    busy_cnt = 0;
    while (!bus.out_valid && cyc < 30) begin
      if (bus.busy) busy_cnt++;
      step();
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("mul_lat", 32'(cyc), 32'd9);
    check("mul_busy", 32'(busy_cnt), 32'd8);
    expect_op("mul", 8'h8F, 4'b1010);
    step();
    check("mul_ignore", 32'(bus.out_valid), 32'd0);
    check("mul_hold", 32'(bus.out_alu), 32'h8F);
    check("mul_idle", 32'(bus.in_ready), 32'd1);
    send(4'd10, 8'h81, 8'd1, 1'b1);
    expect_op("lsr1", 8'h40, 4'b0010);
    send(4'd11, 8'h80, 8'd9, 1'b1);
    expect_op("asr9", 8'hFF, 4'b1010);
    send(4'd9, 8'h01, 8'd0, 1'b1);
    expect_op("lsl0_c1", 8'h01, 4'b0010);
    send(4'd0, 8'hFF, 8'h00, 1'b1);
    expect_op("and", 8'h00, 4'b0100);
    send(4'd9, 8'h01, 8'd0, 1'b1);
    expect_op("lsl0_c0", 8'h01, 4'b0000);
    send(4'd9, 8'h81, 8'd1, 1'b1);
    expect_op("lsl1", 8'h02, 4'b0010);
    send(4'd10, 8'hFF, 8'd9, 1'b1);
    expect_op("lsr9", 8'h00, 4'b0100);
    send(4'd2, 8'h03, 8'h05, 1'b1);
    expect_op("sub_borrow", 8'hFE, 4'b1010);
    send(4'd3, 8'h03, 8'h05, 1'b1);
    expect_op("rsb", 8'h02, 4'b0000);
    send(4'd2, 8'h80, 8'h01, 1'b1);
    expect_op("sub_ovf", 8'h7F, 4'b0001);
    send(4'd6, 8'h05, 8'h03, 1'b1);
    expect_op("sbc", 8'h01, 4'b0000);
    send(4'd15, 8'h00, 8'h0F, 1'b1);
    expect_op("mvn", 8'hF0, 4'b1000);
    send(4'd8, 8'h03, 8'h03, 1'b1);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_ready", 32'(bus.in_ready), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_nzcv", 32'(bus.flags_nzcv), 32'd0);
    check("abort_res", 32'(bus.out_alu), 32'd0);
    seen = 0;
    repeat (12) begin
      step();
      if (bus.out_valid) seen++;
    end
    check("abort_no_pulse", 32'(seen), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
